// File: rtl/ofifo_pkg.sv
// ofifo_pkg: shared accelerator sizing constants and pointer-width helper
package ofifo_pkg;
  localparam int COL = 8;
  localparam int PSUM_BW = 16;
  localparam int DEPTH = 16;
  function automatic int ptr_w(input int d);
    return $clog2(d) + 1;
  endfunction
endpackage

// File: rtl/fifo_lane.sv
// fifo_lane: single-lane circular buffer with wrap-bit pointers and show-ahead head
module fifo_lane import ofifo_pkg::*; #(
  parameter int w = PSUM_BW,
  parameter int depth = DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic         pop,
  input  logic [w-1:0] din,
  output logic [w-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int pw = ptr_w(depth);
  localparam int aw = pw - 1;
  logic [pw-1:0] wp, rp;
  logic [w-1:0] mem [depth];
  assign empty = wp == rp;
  assign full = (wp[aw] != rp[aw]) && (wp[aw-1:0] == rp[aw-1:0]);
  assign head = mem[rp[aw-1:0]];
  // write when not full, pop on row-accept; full/empty come from pre-edge pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      for (int k = 0; k < depth; k++) mem[k] <= '0;
    end else begin
      if (wr && !full) begin
        mem[wp[aw-1:0]] <= din;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/ofifo.sv
// ofifo: per-lane output FIFO popping whole rows; OFIFO_OVF_CHK_EN adds sticky o_ovf_err
module ofifo import ofifo_pkg::*; #(
  parameter int col = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int depth = DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col-1:0]         wr,
  input  logic [col*psum_bw-1:0] in,
  input  logic                   rd,
  output logic [col*psum_bw-1:0] out,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_valid
`ifdef OFIFO_OVF_CHK_EN
  , output logic                 o_ovf_err
`endif
);
  logic [col-1:0] full, empty;
  logic pop;
  assign o_valid = &(~empty);
  assign o_full = |full;
  assign o_ready = !o_full;
  assign pop = rd && o_valid;
  for (genvar i = 0; i < col; i++) begin : g_lane
    fifo_lane #(.w(psum_bw), .depth(depth)) u_lane (
      .clk(clk),
      .reset(reset),
      .wr(wr[i]),
      .pop(pop),
      .din(in[psum_bw*i +: psum_bw]),
      .head(out[psum_bw*i +: psum_bw]),
      .full(full[i]),
      .empty(empty[i])
    );
  end
`ifdef OFIFO_OVF_CHK_EN
  // latch any dropped write until reset
  always_ff @(posedge clk) begin
    if (reset) o_ovf_err <= 1'b0;
    else if (|(wr & full)) o_ovf_err <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_ofifo.sv
// tb_ofifo: directed self-checking bench for ofifo
module tb_ofifo;
  localparam int col = 8;
  localparam int bw = 16;
  localparam int W = col * bw;
  logic clk = 0;
  logic reset = 1;
  logic [col-1:0] wr = '0;
  logic [W-1:0] in = '0;
  logic rd = 0;
  logic [W-1:0] out;
  logic o_full, o_ready, o_valid;
`ifdef OFIFO_OVF_CHK_EN
  logic o_ovf_err;
`endif
  int checks = 0;
  int errors = 0;

  ofifo dut (
    .clk(clk),
    .reset(reset),
    .wr(wr),
    .in(in),
    .rd(rd),
    .out(out),
    .o_full(o_full),
    .o_ready(o_ready),
    .o_valid(o_valid)
`ifdef OFIFO_OVF_CHK_EN
    , .o_ovf_err(o_ovf_err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] row(input int b);
    logic [W-1:0] r;
    for (int i = 0; i < col; i++) r[i*bw +: bw] = 16'(b + i);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; wr = '0; rd = 0;
    step();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    wr = 8'h0F; in = row(7);
    step();
    wr = '1; in = row(20);
    step();
    wr = '0;
    do_reset();
    checks++; if (out !== '0) begin errors++; $display("FAIL reset_out got %h exp 0", out); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", o_valid); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", o_ready); end
    checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", o_full); end
    rd = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rd_empty_valid c%0d got %b exp 0", c, o_valid); end
    end
    rd = 0;
    wr = '1; in = row(50);
    step();
    wr = '0;
    checks++; if (out !== row(50)) begin errors++; $display("FAIL rd_empty_head got %h exp %h", out, row(50)); end
    rd = 1;
    step();
    rd = 0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rd_empty_drain got %b exp 0", o_valid); end
  endtask

  task automatic test_skew();
    do_reset();
    for (int c = 0; c < col; c++) begin
      wr = '0; wr[c] = 1'b1;
      in = '0; in[c*bw +: bw] = 16'(100 + c);
      step();
      checks++; if (o_valid !== (c == col - 1)) begin errors++; $display("FAIL skew_valid c%0d got %b exp %b", c, o_valid, c == col - 1); end
    end
    wr = '0;
    checks++; if (out !== row(100)) begin errors++; $display("FAIL skew_out got %h exp %h", out, row(100)); end
    rd = 1;
    step();
    rd = 0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL skew_pop got %b exp 0", o_valid); end
  endtask

  task automatic test_full();
    do_reset();
    for (int j = 0; j < 16; j++) begin
      wr = '1; in = row(16'h1000 + j*16);
      step();
      if (j == 14) begin
        checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL full_early got %b exp 0", o_full); end
      end
    end
    checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL full_flag got %b exp 1", o_full); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", o_ready); end
    in = {col{16'hBEEF}};
    step();
    checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL full_drop got %b exp 1", o_full); end
    checks++; if (out !== row(16'h1000)) begin errors++; $display("FAIL full_head got %h exp %h", out, row(16'h1000)); end
    rd = 1; in = {col{16'hCAFE}};
    step();
    wr = '0; rd = 0;
    checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL full_simul_drop got %b exp 0", o_full); end
    for (int k = 1; k < 16; k++) begin
      checks++; if (out !== row(16'h1000 + k*16)) begin errors++; $display("FAIL full_order k%0d got %h exp %h", k, out, row(16'h1000 + k*16)); end
      rd = 1;
      step();
      rd = 0;
    end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL full_drained got %b exp 0", o_valid); end
  endtask

  task automatic test_back_to_back();
    wr = '1; in = row(0);
    for (int j = 0; j < 12; j++) step();
    wr = '0; rd = 1;
    for (int j = 0; j < 12; j++) step();
    rd = 0;
    for (int k = 0; k < 5; k++) begin
      wr = '1; in = row(16'h300 + k*16);
      step();
    end
    for (int c = 0; c < 10; c++) begin
      wr = '1; rd = 1; in = row(16'h300 + (c + 5)*16);
      checks++; if (out !== row(16'h300 + c*16)) begin errors++; $display("FAIL b2b_order c%0d got %h exp %h", c, out, row(16'h300 + c*16)); end
      step();
    end
    wr = '0; rd = 0;
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b exp 1", o_valid); end
    checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL b2b_full got %b exp 0", o_full); end
    for (int k = 10; k < 15; k++) begin
      checks++; if (out !== row(16'h300 + k*16)) begin errors++; $display("FAIL b2b_drain k%0d got %h exp %h", k, out, row(16'h300 + k*16)); end
      checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL b2b_occ k%0d got %b exp 1", k, o_valid); end
      rd = 1;
      step();
      rd = 0;
    end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", o_valid); end
  endtask

  task automatic test_signed();
    do_reset();
    wr = '1; in = {col{16'hFFFD}};
    step();
    wr = '0;
    checks++; if (out !== {col{16'hFFFD}}) begin errors++; $display("FAIL signed_out got %h exp %h", out, {col{16'hFFFD}}); end
    rd = 1;
    step();
    rd = 0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL signed_pop got %b exp 0", o_valid); end
  endtask

`ifdef OFIFO_OVF_CHK_EN
  task automatic test_ovf();
    do_reset();
    checks++; if (o_ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_reset got %b exp 0", o_ovf_err); end
    wr = '1; in = row(1);
    for (int j = 0; j < 16; j++) step();
    checks++; if (o_ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_fill got %b exp 0", o_ovf_err); end
    wr = 8'h01;
    step();
    wr = '0;
    checks++; if (o_ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", o_ovf_err); end
    rd = 1;
    for (int j = 0; j < 16; j++) step();
    rd = 0;
    checks++; if (o_ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", o_ovf_err); end
    do_reset();
    checks++; if (o_ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", o_ovf_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_skew();
    test_full();
    test_back_to_back();
    test_signed();
`ifdef OFIFO_OVF_CHK_EN
    test_ovf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ofifo.md
OFIFO -- requirements
Module: ofifo

Interface
REQ-001 SHALL have parameter: col, default 8, number of PE-array columns (lanes).
REQ-002 SHALL have parameter: psum_bw, default 16, partial-sum width per lane.
REQ-003 SHALL have parameter: depth, default 16, entries per lane; power of two, >=2.
REQ-004 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port: wr  input  col  per-lane write strobe from the array's column valid outputs.
REQ-007 SHALL have port: in  input  col*psum_bw  per-lane psum data; lane i at bits [psum_bw*(i+1)-1 : psum_bw*i].
REQ-008 SHALL have port: rd  input  1  row-pop request from the SFP/accumulation controller.
REQ-009 SHALL have port: out  output  col*psum_bw  head row, same lane packing as in, consumed by the SFP stage.
REQ-010 SHALL have port: o_full  output  1  high when any lane holds depth entries.
REQ-011 SHALL have port: o_ready  output  1  exactly !o_full.
REQ-012 SHALL have port: o_valid  output  1  high when every lane holds at least one entry.

Function
REQ-013 SHALL implement col independent circular lanes, each with log2(depth)+1-bit write and read pointers; the MSB is the wrap bit.
REQ-014 SHALL set lane empty when the pointers are equal, and lane full when the low bits are equal and the wrap bits differ.
REQ-015 SHALL store in lane i and advance its write pointer at the edge where wr[i]=1 and lane i is not full; a write to a full lane is dropped with no state change.
REQ-016 SHALL accept a pop only when rd=1 and o_valid=1; then all lanes advance their read pointers at the same edge.
REQ-017 SHALL ignore rd when o_valid=0, including partial-row conditions where some lanes are non-empty.
REQ-018 SHALL evaluate full and empty from pre-edge state: on a full lane, a simultaneous pop and write still drops the write.
REQ-019 SHALL apply a write and an accepted pop to the same non-full lane in one cycle, leaving that lane's occupancy unchanged.
REQ-020 SHALL drive out combinationally (show-ahead) from each lane's storage at the read pointer, so that zero-latency pop data is valid whenever o_valid=1.
REQ-021 SHALL wrap pointers modulo 2*depth with no special-case logic.
REQ-022 SHALL treat data as opaque bits (signed psum passes unchanged) and SHALL NOT perform any arithmetic on data.
REQ-023 SHALL derive o_full, o_ready and o_valid combinationally from pointer registers only.

Reset
REQ-024 SHALL, with reset=1 at an edge, clear all pointers and all storage entries to 0, regardless of wr and rd.
REQ-025 SHALL, in the cycle after reset, present out=0, o_valid=0, o_full=0 and o_ready=1.
REQ-026 SHALL discard all entries when reset is asserted mid-operation; no partial row survives.

Configuration
REQ-027 SHALL, with OFIFO_OVF_CHK_EN defined, add output port o_ovf_err (1 bit), set sticky at the edge after any write is dropped, and clear it only on reset.
REQ-028 SHALL, without OFIFO_OVF_CHK_EN, omit the port and its logic; all other behaviour is identical.

Structure
REQ-029 SHALL take default col, psum_bw and depth constants, and the derived pointer width, from the shared accelerator package also used by the SFP and PSUM-SRAM stages.
REQ-030 SHALL instantiate one sub-module, fifo_lane (single-lane circular buffer exposing full/empty/head), col times via a generate loop.

Verification
REQ-031 SHALL test reset: after reset, out=0, o_valid=0, o_ready=1; rd=1 for 3 cycles -> no pointer change, o_valid stays 0.
REQ-032 SHALL test skewed fill: lane i written with value 100+i starting at cycle i (diagonal skew); o_valid rises only the cycle after lane 7 is written; out lane i=100+i.
REQ-033 SHALL test full: 16 writes to all lanes -> o_full=1, o_ready=0; 17th write (0xBEEF) dropped; 16 pops return original order, then o_valid=0.
REQ-034 SHALL test simultaneous traffic: with 5 entries per lane, wr=all-ones and rd=1 for 10 cycles -> occupancy stays 5 and output order is FIFO-correct across pointer wrap.
REQ-035 SHALL test signed data: write -3 (0xFFFD) to all lanes, then pop -> out lanes equal 0xFFFD unchanged.
REQ-036 SHALL test the macro: with OFIFO_OVF_CHK_EN, a write to a full lane -> o_ovf_err=1 the next cycle; it stays 1 after draining; reset clears it.
